// File: rtl/vocab_reader.sv
// Token-id to text detokenizer: scans the packed, zero-terminated vocab SRAM,
// skips N terminators, then streams word N ending with its terminator beat.
module vocab_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  mem_cs,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic PH_SKIP = 1'b0;
  localparam logic PH_WORD = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_END = {ADDR_WIDTH{1'b1}};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  phase_q, phase_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  at_end;
  logic                  byte_is_term;

  assign at_end       = (ptr_q == ADDR_END);
  assign byte_is_term = (mem_dout == '0);

  assign req_ready = (state_q == S_IDLE);
  assign mem_cs    = (state_q == S_READ);
  assign mem_addr  = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    phase_d     = phase_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          id_d    = req_id;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          phase_d = (req_id == '0) ? PH_WORD : PH_SKIP;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (phase_q == PH_SKIP) begin
          if (byte_is_term) begin
            if ((cnt_q + ID_WIDTH'(1)) == id_q) phase_d = PH_WORD;
            else                                cnt_d   = cnt_q + ID_WIDTH'(1);
          end
          // Running off the end while skipping means the id is out of range.
          if (at_end) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            state_d = S_READ;
          end
        end else begin
          out_data_d  = mem_dout;
          out_valid_d = 1'b1;
          out_last_d  = byte_is_term || at_end;
          ovf_d       = at_end && !byte_is_term;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = ovf_q;
          end else begin
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        ovf_d   = 1'b0;
        cnt_d   = '0;
        phase_d = PH_SKIP;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      phase_q     <= PH_SKIP;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      phase_q     <= phase_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_vocab_reader.sv
// Bench for vocab_reader: SRAM model, word-list reference model and a
// per-cycle compare process, driven by directed token-id requests.
module tb_vocab_reader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_id;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic          err;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] vocab [16];
  logic [8:0] exp_q [$];
  logic       exp_err;
  logic       exp_active = 1'b0;
  int         beats_acc = 0;
  int         accept_cnt = 0;
  int         rdy_mode = 0;
  int         cyc = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  int         f_k, d_k;

  vocab_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_cs) mem_dout <= vocab[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: word N is whatever follows the N-th terminator, up to and
  // including the next terminator or the last address.
  function automatic void build_expect(input int id);
    int p = 0;
    int c = 0;
    exp_q.delete();
    beats_acc = 0;
    while (c < id && p < 16) begin
      if (vocab[p] == 8'h00) c++;
      p++;
    end
    exp_err = 1'b1;
    if (c == id && p < 16) begin
      while (p < 16) begin
        exp_q.push_back({(vocab[p] == 8'h00 || p == 15), vocab[p]});
        if (vocab[p] == 8'h00) begin
          exp_err = 1'b0;
          break;
        end
        p++;
      end
    end
    exp_active = 1'b1;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_cs"},    mem_cs,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_err"},       err,       0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  initial begin
    logic [8:0] beat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (req_valid && req_ready) accept_cnt++;
        if (exp_active) begin
          chk("mem_cs_during_emit", mem_cs && out_valid, 0);
          if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("beat_expected", beats_acc, 32'hFFFF_FFFF);
            end else begin
              beat = exp_q.pop_front();
              chk("beat_data", out_data, beat[7:0]);
              chk("beat_last", out_last, beat[8]);
            end
            beats_acc++;
          end
          if (done) begin
            chk("done_err", err, exp_err);
            chk("done_beats_left", exp_q.size(), 0);
            exp_active = 1'b0;
          end else begin
            chk("err_without_done", err, 0);
          end
        end
        stall_prev = out_valid && !out_ready;
      end
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic run_req(input int id, input int rmode, output int first_k, output int done_k);
    build_expect(id);
    rdy_mode = rmode;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_id    = IW'(id);
    @(posedge clk); #1;
    req_valid = 1'b0;
    first_k = -1;
    done_k  = -1;
    for (int k = 0; k < 300 && done_k < 0; k++) begin
      @(negedge clk); #1;
      if (out_valid && first_k < 0) first_k = k;
      if (done) begin
        done_k = k;
        chk("ready_low_during_done", req_ready, 0);
      end
    end
    chk("done_seen", done_k >= 0, 1);
    exp_active = 1'b0;
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", req_ready, 1);
  endtask

  initial begin
    int dk;
    rst_n = 1'b0; req_valid = 1'b0; req_id = '0;
    vocab[0] = 8'h63; vocab[1] = 8'h61; vocab[2] = 8'h74; vocab[3] = 8'h00;
    vocab[4] = 8'h64; vocab[5] = 8'h6f; vocab[6] = 8'h67; vocab[7] = 8'h00;
    for (int i = 8; i < 16; i++) vocab[i] = 8'h41;

    repeat (2) @(posedge clk);
    #1;
    check_reset("in_reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset("after_reset");

    build_expect(0);
    chk("model_id0_len", exp_q.size(), 4);
    chk("model_id0_first", exp_q[0], 9'h063);
    chk("model_id0_lastbeat", exp_q[3], 9'h100);
    chk("model_id0_err", exp_err, 0);
    build_expect(2);
    chk("model_id2_len", exp_q.size(), 8);
    chk("model_id2_lastbeat", exp_q[7], 9'h141);
    chk("model_id2_err", exp_err, 1);
    build_expect(3);
    chk("model_id3_len", exp_q.size(), 0);
    chk("model_id3_err", exp_err, 1);
    exp_active = 1'b0;

    run_req(0, 0, f_k, d_k);
    chk("id0_first_valid_cycle", f_k, 2);
    chk("id0_done_cycle", d_k, 12);

    run_req(1, 1, f_k, d_k);

    run_req(2, 0, f_k, d_k);
    chk("id2_first_valid_cycle", f_k, 18);
    chk("id2_done_cycle", d_k, 40);

    run_req(3, 0, f_k, d_k);
    chk("id3_no_valid", f_k, 32'hFFFF_FFFF);
    chk("id3_done_cycle", d_k, 32);

    // Abandon an id=1 stream right after its second beat.
    build_expect(1);
    rdy_mode = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_id = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 100 && beats_acc < 2; k++) begin
      @(negedge clk); #1;
    end
    chk("rst_two_beats", beats_acc, 2);
    @(posedge clk); #3;
    exp_active = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("mid_stream");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // req_valid held high for the whole first request.
    build_expect(0);
    rdy_mode = 1;
    accept_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_id = 4'd0;
    dk = -1;
    for (int k = 0; k < 300 && dk < 0; k++) begin
      @(negedge clk); #1;
      if (done) begin
        dk = k;
        chk("held_ready_in_done", req_ready, 0);
        chk("held_single_accept", accept_cnt, 1);
      end
    end
    chk("held_done_seen", dk >= 0, 1);
    build_expect(0);
    @(negedge clk); #1;
    chk("held_ready_after_done", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    dk = -1;
    for (int k = 0; k < 300 && dk < 0; k++) begin
      @(negedge clk); #1;
      if (done) dk = k;
    end
    chk("held_second_done_seen", dk >= 0, 1);
    chk("held_second_accept", accept_cnt, 2);
    exp_active = 1'b0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
